mmio_io_controller: RTL and testbench
=====================================

Name: mmio_io_controller

Overview:
- Parametrised memory-mapped I/O block between the processor data-memory port and the RAM.
- Replaces the single hard-wired button-in / value-out decode with NUM_IN debounced, edge-latched input channels and NUM_OUT writable, readable output registers.
- Unmapped accesses pass through to RAM unchanged.
- Mapped writes are kept out of RAM.

Parameters:
- NUM_IN, 4, number of input (button) channels, 1..16.
- NUM_OUT, 4, number of output registers, 1..16.
- OUT_WIDTH, 32, width of each output register, 1..32.
- DEBOUNCE_CYCLES, 16, consecutive stable synchronized samples needed to accept a level change, >=1.
- IN_BASE, 32'd1000, word address of input channel 0; channel i is at IN_BASE+i.
- OUT_BASE, 32'd2000, word address of output register 0; register j is at OUT_BASE+j.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- address_dmem  in  32  processor data address.
- wren  in  1  processor data write enable.
- data  in  32  processor write data.
- q_dmem  out  32  read data returned to processor (combinational).
- mem_q  in  32  read data from RAM.
- mem_wren  out  1  write enable forwarded to RAM.
- btn_raw  in  NUM_IN  asynchronous raw button levels.
- out_regs  out  NUM_OUT*OUT_WIDTH  output registers, register j at bits [j*OUT_WIDTH +: OUT_WIDTH].
- out_strobe  out  NUM_OUT  one-cycle pulse, bit j, on each write to register j.
- btn_stable  out  NUM_IN  debounced levels.

Behaviour:
- Reset (reset=0, asynchronous):
  - Sync flops, stable levels, debounce counters, sticky flags, out_regs and out_strobe all go to 0.
  - No state changes while reset=0.
- Decode on the full 32-bit address:
  - in_hit when IN_BASE <= address_dmem < IN_BASE+NUM_IN.
  - out_hit when OUT_BASE <= address_dmem < OUT_BASE+NUM_OUT.
  - Parameters guarantee the two ranges do not overlap.
- mem_wren = wren & ~in_hit & ~out_hit.
- q_dmem (combinational, no added latency):
  - in_hit: {30'b0, sticky[i], stable[i]}.
  - out_hit: out_regs[j] zero-extended to 32 bits.
  - Otherwise: mem_q.
- Synchronizer: two flops per channel; sync2 lags btn_raw by two edges.
- Debounce, per channel:
  - If sync2 == stable, counter clears to 0.
  - Otherwise the counter increments.
  - When the counter equals DEBOUNCE_CYCLES-1 and sync2 != stable, stable takes sync2 and the counter clears.
  - Net effect: stable flips exactly DEBOUNCE_CYCLES edges after sync2 first differs.
  - Any bounce back (sync2 == stable) before that restarts the count.
- Sticky flag:
  - Set on the edge where stable goes 0->1.
  - Cleared on any write (wren=1, any data) to IN_BASE+i.
  - If set and clear fall on the same edge, set wins (flag stays 1).
  - A falling stable edge does not affect sticky.
- Output registers:
  - On wren & out_hit, register j loads data[OUT_WIDTH-1:0] at the edge; upper data bits are ignored.
  - out_strobe[j] is 1 for the following cycle only.
  - Back-to-back writes give consecutive strobe cycles.
  - A read in the cycle after a write returns the new value.
- Simultaneous events: a write to an output register and a debounce event on an input channel are independent; both take effect on the same edge.
- Reset mid-debounce discards the partial count; the channel restarts from stable=0.

Test Plan:
- Reset, then btn_raw=0 held; read 1000 -> q_dmem=0. Release reset; write 2001 with data 32'h0000_00A5 -> out_regs[1]=A5, out_strobe=4'b0010 for exactly one cycle, RAM mem_wren=0.
- DEBOUNCE_CYCLES=4: raise btn_raw[2] cleanly -> btn_stable[2] rises 6 edges after first sample (2 sync + 4); read 1002 -> 32'd3.
- Bounce btn_raw[0] 1 for 3 cycles, 0 for 1, then 1 steady, with DEBOUNCE_CYCLES=4 -> stable[0] rises only after 4 consecutive 1 samples from the last rise; sticky[0] set once.
- Write 1002 (any data) -> next read returns 32'd1 (sticky cleared, level held). Repeat the clear on the same edge as a fresh rising stable edge -> read returns 3 (set wins).
- Access 1500 and 2004 (NUM_OUT=4): write data 7 -> mem_wren=1 and q_dmem equals mem_q on read; out_regs and sticky flags unchanged.
- Assert reset low mid-count with out_regs[0]=5 -> all outputs 0 immediately, without waiting for a clock edge; after release the debounce count restarts from 0.

Source files
------------

// File: rtl/mmio_io_controller.sv
// mmio_io_controller: memory-mapped I/O shim between the processor data port
// and RAM. It has NUM_IN debounced, edge-latched button channels and NUM_OUT
// writable and readable output registers. Unmapped accesses go through to RAM
// unchanged. Mapped writes never reach RAM.
module mmio_io_controller #(
  parameter int unsigned NUM_IN          = 4,
  parameter int unsigned NUM_OUT         = 4,
  parameter int unsigned OUT_WIDTH       = 32,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter logic [31:0] IN_BASE         = 32'd1000,
  parameter logic [31:0] OUT_BASE        = 32'd2000
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [31:0]                    address_dmem,
  input  logic                           wren,
  input  logic [31:0]                    data,
  output logic [31:0]                    q_dmem,
  input  logic [31:0]                    mem_q,
  output logic                           mem_wren,
  input  logic [NUM_IN-1:0]              btn_raw,
  output logic [NUM_OUT*OUT_WIDTH-1:0]   out_regs,
  output logic [NUM_OUT-1:0]             out_strobe,
  output logic [NUM_IN-1:0]              btn_stable
);

  // Index widths. Each is clamped to at least one bit so single-channel
  // builds still elaborate.
  localparam int unsigned IN_IW  = (NUM_IN  > 1) ? $clog2(NUM_IN)  : 1;
  localparam int unsigned OUT_IW = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
  localparam int unsigned CNT_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  // Exclusive upper bounds of the two mapped windows.
  localparam logic [31:0] IN_END  = IN_BASE  + 32'(NUM_IN);
  localparam logic [31:0] OUT_END = OUT_BASE + 32'(NUM_OUT);

  // The last count before an accepted level change.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  // ---------------------------------------------------------------------------
  // Address decode, done on the full 32-bit address
  // ---------------------------------------------------------------------------
  logic              in_hit;
  logic              out_hit;
  logic [IN_IW-1:0]  in_idx;
  logic [OUT_IW-1:0] out_idx;

  assign in_hit  = (address_dmem >= IN_BASE)  && (address_dmem < IN_END);
  assign out_hit = (address_dmem >= OUT_BASE) && (address_dmem < OUT_END);
  assign in_idx  = IN_IW'(address_dmem - IN_BASE);
  assign out_idx = OUT_IW'(address_dmem - OUT_BASE);

  // RAM only sees writes that fall outside both mapped windows.
  assign mem_wren = wren & ~in_hit & ~out_hit;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [NUM_IN-1:0]            sync1_q,  sync1_d;
  logic [NUM_IN-1:0]            sync2_q,  sync2_d;
  logic [NUM_IN-1:0]            stable_q, stable_d;
  logic [NUM_IN-1:0]            sticky_q, sticky_d;
  logic [CNT_W-1:0]             cnt_q [NUM_IN];
  logic [CNT_W-1:0]             cnt_d [NUM_IN];
  logic [NUM_OUT*OUT_WIDTH-1:0] out_q,    out_d;
  logic [NUM_OUT-1:0]           strobe_q, strobe_d;

  assign out_regs   = out_q;
  assign out_strobe = strobe_q;
  assign btn_stable = stable_q;

  // ---------------------------------------------------------------------------
  // Read-back mux (combinational, adds no latency)
  // ---------------------------------------------------------------------------
  logic [31:0] out_lsb;
  logic [31:0] rd_word;

  assign out_lsb = 32'(out_idx) * OUT_WIDTH;

  // Choose the read data: input channel status, an output register, or RAM.
  always_comb begin
    rd_word = mem_q;
    if (in_hit) begin
      rd_word = {30'd0, sticky_q[in_idx], stable_q[in_idx]};
    end else if (out_hit) begin
      rd_word = 32'd0;
      rd_word[OUT_WIDTH-1:0] = out_q[out_lsb +: OUT_WIDTH];
    end else begin
      rd_word = mem_q;
    end
  end

  assign q_dmem = rd_word;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------

  // Input path: synchronise, debounce, then latch rising edges into the
  // sticky flags.
  always_comb begin
    sync1_d  = btn_raw;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    sticky_d = sticky_q;
    for (int i = 0; i < int'(NUM_IN); i++) begin
      cnt_d[i] = cnt_q[i];
    end
    for (int i = 0; i < int'(NUM_IN); i++) begin
      // Any sample equal to the current stable level restarts the count.
      // Otherwise the count runs until it reaches CNT_MAX, and the next
      // disagreeing sample flips the level.
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        stable_d[i] = sync2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
      // A write to the channel clears its flag. A rising stable edge on the
      // same clock edge overrides the clear.
      sticky_d[i] = (sticky_q[i] & ~(wren & in_hit & (in_idx == IN_IW'(i))))
                  | (stable_d[i] & ~stable_q[i]);
    end
  end

  // Output path: load the addressed register and raise its strobe for one
  // cycle.
  always_comb begin
    out_d    = out_q;
    strobe_d = '0;
    for (int j = 0; j < int'(NUM_OUT); j++) begin
      if (wren && out_hit && (out_idx == OUT_IW'(j))) begin
        strobe_d[j] = 1'b1;
        out_d[j*OUT_WIDTH +: OUT_WIDTH] = data[OUT_WIDTH-1:0];
      end else begin
        strobe_d[j] = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------

  // State update. Asserting reset clears everything at once, including any
  // partial debounce count.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      sticky_q <= '0;
      for (int i = 0; i < int'(NUM_IN); i++) begin
        cnt_q[i] <= '0;
      end
      out_q    <= '0;
      strobe_q <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      sticky_q <= sticky_d;
      for (int i = 0; i < int'(NUM_IN); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      out_q    <= out_d;
      strobe_q <= strobe_d;
    end
  end

endmodule

// File: tb/tb_mmio_io_controller.sv
// Testbench for mmio_io_controller (DEBOUNCE_CYCLES = 4). Stimulus pushes
// expected responses into scoreboard queues, and a negedge monitor pops and
// compares them when the DUT presents a response.
module tb_mmio_io_controller;

  localparam int NI = 4;
  localparam int NO = 4;
  localparam int OW = 32;

  localparam int K_QD   = 0;  // compare q_dmem
  localparam int K_MW   = 1;  // compare mem_wren
  localparam int K_ZERO = 2;  // out_regs, out_strobe and btn_stable all zero

  typedef struct {
    string       name;
    int          kind;
    logic [31:0] exp;
  } probe_t;

  typedef struct {
    int          idx;
    logic [31:0] val;
  } wr_t;

  typedef struct {
    int   bit_i;
    logic lvl;
    int   cyc;
  } st_t;

  logic              clock;
  logic              reset;
  logic [31:0]       address_dmem;
  logic              wren;
  logic [31:0]       data;
  logic [31:0]       q_dmem;
  logic [31:0]       mem_q;
  logic              mem_wren;
  logic [NI-1:0]     btn_raw;
  logic [NO*OW-1:0]  out_regs;
  logic [NO-1:0]     out_strobe;
  logic [NI-1:0]     btn_stable;

  probe_t probe_q[$];
  wr_t    wr_q[$];
  st_t    st_q[$];
  logic   probe;
  int     cyc;
  int     checks;
  int     errors;
  logic [NI-1:0] prev_stable;

  mmio_io_controller #(
    .NUM_IN(NI), .NUM_OUT(NO), .OUT_WIDTH(OW), .DEBOUNCE_CYCLES(4),
    .IN_BASE(32'd1000), .OUT_BASE(32'd2000)
  ) dut (
    .clock(clock), .reset(reset), .address_dmem(address_dmem), .wren(wren),
    .data(data), .q_dmem(q_dmem), .mem_q(mem_q), .mem_wren(mem_wren),
    .btn_raw(btn_raw), .out_regs(out_regs), .out_strobe(out_strobe),
    .btn_stable(btn_stable)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: consume expected responses whenever the DUT presents one.
  always @(negedge clock) begin
    probe_t p;
    wr_t    w;
    int     found;
    if (probe) begin
      while (probe_q.size() > 0) begin
        p = probe_q.pop_front();
        case (p.kind)
          K_QD:    check(p.name, q_dmem, p.exp);
          K_MW:    check(p.name, {31'd0, mem_wren}, p.exp);
          default: check(p.name, {31'd0, (out_regs != '0) || (out_strobe != '0) || (btn_stable != '0)}, p.exp);
        endcase
      end
    end
    if (out_strobe != '0) begin
      if (wr_q.size() == 0) begin
        check("strobe_unexpected", {28'd0, out_strobe}, 32'd0);
      end else begin
        w = wr_q.pop_front();
        check("strobe", {28'd0, out_strobe}, 32'd1 << w.idx);
        check("out_reg", out_regs[w.idx*OW +: OW], w.val);
      end
    end
    if (reset && (btn_stable != prev_stable)) begin
      for (int b = 0; b < NI; b++) begin
        if (btn_stable[b] != prev_stable[b]) begin
          found = -1;
          for (int k = 0; k < st_q.size(); k++) begin
            if (found < 0 && st_q[k].bit_i == b) found = k;
          end
          if (found < 0) begin
            check("stable_unexpected", 32'(b), 32'hFFFF_FFFF);
          end else begin
            check("stable_lvl", {31'd0, btn_stable[b]}, {31'd0, st_q[found].lvl});
            check("stable_cyc", 32'(cyc), 32'(st_q[found].cyc));
            st_q.delete(found);
          end
        end
      end
    end
    prev_stable = btn_stable;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push_probe(input string name, input int kind, input logic [31:0] exp);
    probe_t p;
    p.name = name;
    p.kind = kind;
    p.exp  = exp;
    probe_q.push_back(p);
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] mq, input logic [31:0] exp, input string name);
    address_dmem = addr;
    wren = 1'b0;
    mem_q = mq;
    push_probe(name, K_QD, exp);
    probe = 1'b1;
    step();
    probe = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] d, input logic mw_exp, input string name);
    address_dmem = addr;
    data = d;
    wren = 1'b1;
    push_probe(name, K_MW, {31'd0, mw_exp});
    probe = 1'b1;
    step();
    wren = 1'b0;
    probe = 1'b0;
  endtask

  task automatic wr_out(input int j, input logic [31:0] d);
    wr_t w;
    w.idx = j;
    w.val = d;
    wr_q.push_back(w);
    wr(32'd2000 + 32'(j), d, 1'b0, "mw_out");
  endtask

  task automatic expect_stable(input int b, input logic lvl, input int at);
    st_t s;
    s.bit_i = b;
    s.lvl = lvl;
    s.cyc = at;
    st_q.push_back(s);
  endtask

  task automatic wait_cycles(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; errors = 0; cyc = 0; probe = 1'b0;
    prev_stable = '0;
    reset = 1'b0; address_dmem = 32'd1000; wren = 1'b0; data = 32'd0;
    mem_q = 32'hDEAD_BEEF; btn_raw = '0;
    wait_cycles(2);

    // Reset state: status read is 0 and every register output is 0.
    push_probe("reset_outputs", K_ZERO, 32'd0);
    rd(32'd1000, 32'hDEAD_BEEF, 32'd0, "rd_reset_1000");
    reset = 1'b1;
    step();

    // Output register write, then a read in the very next cycle.
    wr_out(1, 32'h0000_00A5);
    rd(32'd2001, 32'h1111_1111, 32'h0000_00A5, "rd_2001_after_wr");
    rd(32'd2000, 32'h1111_1111, 32'd0, "rd_2000_untouched");

    // Clean rise on channel 2: stable rises 6 edges after the change.
    btn_raw[2] = 1'b1;
    expect_stable(2, 1'b1, cyc + 6);
    wait_cycles(8);
    rd(32'd1002, 32'h0, 32'd3, "rd_1002_rise");

    // Bouncing rise on channel 0 (1,1,1,0,1...): count restarts at the bounce.
    btn_raw[0] = 1'b1;
    expect_stable(0, 1'b1, cyc + 10);
    wait_cycles(3);
    btn_raw[0] = 1'b0;
    step();
    btn_raw[0] = 1'b1;
    wait_cycles(9);
    rd(32'd1000, 32'h0, 32'd3, "rd_1000_bounce");

    // Clearing sticky[2] by a write keeps the level bit.
    wr(32'd1002, 32'hFFFF_FFFF, 1'b0, "mw_in_clear");
    rd(32'd1002, 32'h0, 32'd1, "rd_1002_cleared");

    // Set wins: the clear write lands on the same edge as stable[3] rising.
    btn_raw[3] = 1'b1;
    expect_stable(3, 1'b1, cyc + 6);
    wait_cycles(5);
    wr(32'd1003, 32'd0, 1'b0, "mw_in_setwins");
    rd(32'd1003, 32'h0, 32'd3, "rd_1003_setwins");

    // A falling stable edge leaves sticky set.
    btn_raw[3] = 1'b0;
    expect_stable(3, 1'b0, cyc + 6);
    wait_cycles(8);
    rd(32'd1003, 32'h0, 32'd2, "rd_1003_fall");

    // Unmapped accesses, including the addresses just past each window.
    wr(32'd1500, 32'd7, 1'b1, "mw_1500");
    rd(32'd1500, 32'h1234_5678, 32'h1234_5678, "rd_1500");
    wr(32'd2004, 32'd7, 1'b1, "mw_2004");
    rd(32'd2004, 32'hCAFE_0001, 32'hCAFE_0001, "rd_2004");
    rd(32'd1004, 32'h0BAD_0004, 32'h0BAD_0004, "rd_1004");
    rd(32'd999,  32'h0BAD_0999, 32'h0BAD_0999, "rd_999");
    rd(32'd1999, 32'h0BAD_1999, 32'h0BAD_1999, "rd_1999");
    rd(32'd2001, 32'h0, 32'h0000_00A5, "rd_2001_kept");
    rd(32'd1000, 32'h0, 32'd3, "rd_1000_kept");

    // Back-to-back writes produce strobes on consecutive cycles.
    wr_out(0, 32'd5);
    wr_out(3, 32'h8000_0001);
    rd(32'd2000, 32'h0, 32'd5, "rd_2000_b2b");
    rd(32'd2003, 32'h0, 32'h8000_0001, "rd_2003_b2b");

    // Reset mid-count on channel 1: outputs clear before any clock edge.
    btn_raw[1] = 1'b1;
    wait_cycles(3);
    #2;
    address_dmem = 32'd1000;
    reset = 1'b0;
    push_probe("midreset_outputs", K_ZERO, 32'd0);
    push_probe("midreset_q_dmem", K_QD, 32'd0);
    probe = 1'b1;
    step();
    probe = 1'b0;
    step();
    reset = 1'b1;
    expect_stable(0, 1'b1, cyc + 6);
    expect_stable(1, 1'b1, cyc + 6);
    expect_stable(2, 1'b1, cyc + 6);
    wait_cycles(8);
    rd(32'd1001, 32'h0, 32'd3, "rd_1001_after_reset");
    rd(32'd1003, 32'h0, 32'd0, "rd_1003_after_reset");
    rd(32'd2000, 32'h0, 32'd0, "rd_2000_after_reset");
    wait_cycles(2);

    check("wr_q_empty", 32'(wr_q.size()), 32'd0);
    check("st_q_empty", 32'(st_q.size()), 32'd0);
    check("probe_q_empty", 32'(probe_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
